// File: rtl/lc4_multiplier_seq_pkg.sv
// Shared LC4 multiplier definitions: FSM state encoding and datapath word width.
package lc4_multiplier_seq_pkg;

    localparam int LC4_WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage : lc4_multiplier_seq_pkg

// File: rtl/lc4_multiplier_one_iter.sv
// One shift-add step of the iterative multiplier: retires BITS_PER_CYCLE
// multiplier bits into the accumulator and advances both operand registers.
module lc4_multiplier_one_iter
    import lc4_multiplier_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*LC4_WORD_W-1:0] i_acc,
    input  logic [2*LC4_WORD_W-1:0] i_a,
    input  logic [LC4_WORD_W-1:0]   i_b,
    output logic [2*LC4_WORD_W-1:0] o_acc,
    output logic [2*LC4_WORD_W-1:0] o_a,
    output logic [LC4_WORD_W-1:0]   o_b
);

    logic [2*LC4_WORD_W-1:0] digit_s;
    logic [2*LC4_WORD_W-1:0] partial_s;

    // Partial product of the shifted multiplicand and the low multiplier digit,
    // accumulated modulo 2^32, then both operands advance by one digit.
    always_comb begin
        digit_s   = {{(2*LC4_WORD_W-BITS_PER_CYCLE){1'b0}}, i_b[BITS_PER_CYCLE-1:0]};
        partial_s = i_a * digit_s;
        o_acc     = i_acc + partial_s;
        o_a       = i_a << BITS_PER_CYCLE;
        o_b       = i_b >> BITS_PER_CYCLE;
    end

endmodule : lc4_multiplier_one_iter

// File: rtl/lc4_multiplier_seq.sv
// Iterative unsigned 16x16 multiplier: fixed-latency shift-add loop with a
// registered 32-bit product and a one-cycle valid pulse; o_busy stalls the pipe.
module lc4_multiplier_seq
    import lc4_multiplier_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gwe,
    input  logic                  i_start,
    input  logic [LC4_WORD_W-1:0] i_multiplicand,
    input  logic [LC4_WORD_W-1:0] i_multiplier,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [LC4_WORD_W-1:0] o_product_lo,
    output logic [LC4_WORD_W-1:0] o_product_hi
);

    localparam int ITERS = LC4_WORD_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS);

    mul_state_t              state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [2*LC4_WORD_W-1:0] acc_q,     acc_d;
    logic [2*LC4_WORD_W-1:0] a_q,       a_d;
    logic [LC4_WORD_W-1:0]   b_q,       b_d;
    logic                    busy_q,    busy_d;
    logic                    valid_q,   valid_d;
    logic [LC4_WORD_W-1:0]   prod_lo_q, prod_lo_d;
    logic [LC4_WORD_W-1:0]   prod_hi_q, prod_hi_d;

    logic [2*LC4_WORD_W-1:0] iter_acc_s;
    logic [2*LC4_WORD_W-1:0] iter_a_s;
    logic [LC4_WORD_W-1:0]   iter_b_s;

    lc4_multiplier_one_iter #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_one_iter (
        .i_acc (acc_q),
        .i_a   (a_q),
        .i_b   (b_q),
        .o_acc (iter_acc_s),
        .o_a   (iter_a_s),
        .o_b   (iter_b_s)
    );

    // Next-state logic: operand capture on accept, one step per RUN cycle,
    // product capture on the final step. Products hold outside DONE entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        prod_lo_d = prod_lo_q;
        prod_hi_d = prod_hi_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    a_d     = {{LC4_WORD_W{1'b0}}, i_multiplicand};
                    b_d     = i_multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = iter_acc_s;
                a_d   = iter_a_s;
                b_d   = iter_b_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    valid_d   = 1'b1;
                    prod_lo_d = iter_acc_s[LC4_WORD_W-1:0];
                    prod_hi_d = iter_acc_s[2*LC4_WORD_W-1:LC4_WORD_W];
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                // A start seen here is accepted back-to-back, same as in IDLE.
                if (i_start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    a_d     = {{LC4_WORD_W{1'b0}}, i_multiplicand};
                    b_d     = i_multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers: synchronous reset has priority over gwe,
    // and gwe=0 freezes everything (so o_valid stretches while DONE is held).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            prod_lo_q <= '0;
            prod_hi_q <= '0;
        end else if (gwe) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            prod_lo_q <= prod_lo_d;
            prod_hi_q <= prod_hi_d;
        end else begin
            state_q   <= state_q;
            cnt_q     <= cnt_q;
            acc_q     <= acc_q;
            a_q       <= a_q;
            b_q       <= b_q;
            busy_q    <= busy_q;
            valid_q   <= valid_q;
            prod_lo_q <= prod_lo_q;
            prod_hi_q <= prod_hi_q;
        end
    end

    assign o_busy       = busy_q;
    assign o_valid      = valid_q;
    assign o_product_lo = prod_lo_q;
    assign o_product_hi = prod_hi_q;

endmodule : lc4_multiplier_seq
